// File: rtl/hamming_tx_encoder.sv
// hamming_tx_encoder
// Transmit side of the 16-bit extended Hamming link. Each accepted message
// byte becomes two (8,4) codewords, {enc(high nibble), enc(low nibble)},
// which are shifted out MSB-first with every bit held for BIT_CYCLES clocks.
// A single holding buffer lets the next byte be taken while the current frame
// is still on the line, so consecutive frames follow each other with no gap.
// BIT_CYCLES must lie in 1..256.
module hamming_tx_encoder #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       tx_start,
  output logic       tx_done
);

  // A one-bit counter is kept even when BIT_CYCLES is 1 so the logic below
  // needs no special case; it simply never leaves zero.
  localparam int              CycW    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(BIT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      bitCnt_q, bitCnt_d;
  logic [CycW-1:0] cycCnt_q, cycCnt_d;
  logic [15:0]     shiftReg_q, shiftReg_d;
  logic [15:0]     holdBuf_q, holdBuf_d;
  logic            bufFull_q, bufFull_d;

  logic [15:0]     codeword;
  logic            accept;
  logic            bitLast;
  logic            frameLast;

  // Extended Hamming (8,4): data on bits 7,6,5,3, parity on 4,2,1 and an
  // overall even-parity bit on bit 0 covering the other seven.
  function automatic logic [7:0] encodeNibble(input logic [3:0] d);
    logic [7:1] upper;
    upper = {d[3], d[2], d[1],
             d[1] ^ d[2] ^ d[3],
             d[0],
             d[0] ^ d[2] ^ d[3],
             d[0] ^ d[1] ^ d[3]};
    return {upper, ^upper};
  endfunction

  // Only the encoded word is stored, so encoding happens at accept time.
  assign codeword = {encodeNibble(in_data[7:4]), encodeNibble(in_data[3:0])};

  // The buffer is the only thing that can refuse a byte; reset also refuses.
  assign in_ready  = !reset && !bufFull_q;
  assign accept    = in_valid && in_ready;
  assign bitLast   = (cycCnt_q == CycLast);
  assign frameLast = (state_q == SHIFT) && (bitCnt_q == 4'd0) && bitLast;

  // Next-state logic: bit timing, shifting, buffer fill and frame chaining.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    cycCnt_d   = cycCnt_q;
    shiftReg_d = shiftReg_q;
    holdBuf_d  = holdBuf_q;
    bufFull_d  = bufFull_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SHIFT;
          shiftReg_d = codeword;
          bitCnt_d   = 4'd15;
          cycCnt_d   = '0;
        end
      end

      SHIFT: begin
        if (!bitLast) begin
          cycCnt_d = cycCnt_q + 1'b1;
        end else if (bitCnt_q != 4'd0) begin
          cycCnt_d   = '0;
          bitCnt_d   = bitCnt_q - 4'd1;
          shiftReg_d = {shiftReg_q[14:0], 1'b0};
        end else begin
          // Last cycle of bit 0: chain the next frame if one is available,
          // preferring the buffered byte since it arrived first.
          cycCnt_d = '0;
          bitCnt_d = 4'd15;
          if (bufFull_q) begin
            shiftReg_d = holdBuf_q;
            bufFull_d  = 1'b0;
          end else if (accept) begin
            shiftReg_d = codeword;
          end else begin
            state_d    = IDLE;
            shiftReg_d = '0;
          end
        end

        // A byte taken mid-frame waits in the buffer; one taken on the final
        // cycle was already routed straight into the shift register above.
        if (accept && !frameLast) begin
          holdBuf_d = codeword;
          bufFull_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      cycCnt_q   <= '0;
      shiftReg_q <= '0;
      holdBuf_q  <= '0;
      bufFull_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      cycCnt_q   <= cycCnt_d;
      shiftReg_q <= shiftReg_d;
      holdBuf_q  <= holdBuf_d;
      bufFull_q  <= bufFull_d;
    end
  end

  // Line outputs are decoded from registered state, so all are zero in IDLE.
  always_comb begin
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    tx_start = 1'b0;
    tx_done  = 1'b0;
    if (state_q == SHIFT) begin
      tx_valid = 1'b1;
      tx_bit   = shiftReg_q[15];
      tx_start = (bitCnt_q == 4'd15) && (cycCnt_q == '0);
      tx_done  = frameLast;
    end
  end

endmodule

// File: doc/hamming_tx_encoder.md
# hamming_tx_encoder

Transmit-side counterpart of the 16-bit Hamming decoder. Accepts message bytes over a valid/ready handshake and encodes each byte as two extended Hamming (8,4) codewords, high nibble into codeword[15:8] and low nibble into codeword[7:0]. Each 16-bit codeword is serialized MSB-first onto a single-bit line at a programmable bit period. A one-byte holding buffer allows back-to-back frames with no idle gap; it sits between the message source and the physical line driver.

## Interface
- BIT_CYCLES, default 4: clock cycles per transmitted bit; legal range 1..256.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  message byte to encode.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- tx_bit  output  1  serial codeword bit, MSB (codeword[15]) first.
- tx_valid  output  1  high while a frame is being driven on tx_bit.
- tx_start  output  1  one-cycle pulse on the first cycle of each frame's bit 15.
- tx_done  output  1  one-cycle pulse on the last cycle of each frame's bit 0.

## Operation
- Nibble encoding, data d[3:0], bit positions within a byte:
  - Data bits: [7]=d3, [6]=d2, [5]=d1, [3]=d0.
  - Parity bits: [4]=p3=d1^d2^d3, [2]=p2=d0^d2^d3, [1]=p1=d0^d1^d3.
  - Overall parity: [0]=p0 = XOR of bits [7:1] (even overall parity).
- codeword = {enc(in_data[7:4]), enc(in_data[3:0])}.
- State machine:
  - IDLE: tx_valid=0, tx_bit=0.
  - SHIFT: driving a frame; bit_cnt counts 15→0, cyc_cnt counts 0→BIT_CYCLES-1 within each bit.
- Holding buffer: one entry, with a buf_full flag; in_ready = !buf_full while reset is low, and in_ready = 0 while reset is high.
- Accepted byte routing:
  - In IDLE, an accepted byte goes straight to the shift register and the FSM enters SHIFT.
  - In SHIFT, an accepted byte goes to the buffer and buf_full is set.
- End of frame (last cycle of bit 0):
  - If buf_full, the buffered codeword loads into the shift register and buf_full clears. The next frame starts the following cycle with no gap.
  - Otherwise, if a byte is accepted that same cycle, it loads directly as the next frame with no gap.
  - Otherwise the FSM returns to IDLE.
- Encoding is combinational on in_data at accept time. Only the encoded 16-bit codeword is stored.
- Reset clears the FSM to IDLE and clears buf_full, both counters, the shift register and all outputs. A frame in progress is abandoned with no tx_done pulse.

## Timing
- Reset values: in_ready=0 while reset is high and 1 in the first cycle after release; tx_bit=0, tx_valid=0, tx_start=0, tx_done=0.
- Latency: a byte accepted at edge N in IDLE gives tx_valid=1, tx_start=1 and tx_bit=codeword[15] in cycle N+1.
- Each bit is held for exactly BIT_CYCLES cycles; a frame lasts 16*BIT_CYCLES cycles.
- tx_done is high in the final cycle of the frame. With back-to-back frames, tx_start follows tx_done in the next cycle and tx_valid stays high throughout.
- in_ready is low from the cycle after the buffer fills until the cycle after the buffer drains into the shift register.
- BIT_CYCLES=1: one bit per cycle; tx_start and tx_done fall in different cycles, 15 cycles apart.
- in_valid asserted with in_ready low: the byte is not taken, and in_data must be held by the source.

## Test plan
- Reset, then accept 0xA5 with BIT_CYCLES=4 → tx_start in cycle N+1; tx_bit sequence over 64 cycles is 0xA55A MSB-first; tx_done in the last cycle; then IDLE with tx_bit=0.
- Encode sweep: 0x00→0x0000, 0xFF→0xFFFF, 0x11→0x0F0F, 0x55→0x5A5A; loop all 256 bytes through the reference decoder → msg equals the input byte and errors=0.
- Back-to-back: offer 0x12, 0x34 and 0x56 continuously → second byte buffered, in_ready low until drain; three frames with tx_valid continuously high and no gap cycles.
- Accept on the final bit cycle with the buffer empty → next frame starts the following cycle; no IDLE cycle.
- Assert reset mid-frame (bit 9) → next cycle all outputs are 0, no tx_done, buffer empty; a new byte after release transmits correctly.
- BIT_CYCLES=1 and BIT_CYCLES=256 → bit widths are exactly 1 and 256 cycles respectively; frame lengths are 16 and 4096 cycles.
